count_sequence_checker: RTL and testbench
=========================================

// Module: count_sequence_checker
// PURPOSE
//   Receive-side checker for the bounded up/down count stream from the processor's sequence counter.
//   Tracks the sampled count values and predicts each next value from the same up/down/select
//   configuration the counter uses.
//   Declares lock after a run of matching samples, then flags and counts every deviation.
//   Sits beside the counter (or at a remote consumer of its count bus) as a run-time integrity monitor.
// PARAMETERS
//   WIDTH    7   width of count, up, down; all arithmetic is modulo 2^WIDTH
//   LOCK_N   4   consecutive matching samples required to enter LOCKED (>=1)
//   UNLOCK_N 3   consecutive mismatches in LOCKED that force return to ACQ (>=1)
// PORTS
//   clk        in   1      clock, all state updates on rising edge
//   rst        in   1      synchronous, active-high reset
//   count_in   in   WIDTH  sampled count value
//   valid      in   1      count_in is a new sample this cycle; ignored when low
//   up         in   WIDTH  upper turn value (same meaning as the counter's up)
//   down       in   WIDTH  lower turn value (same meaning as the counter's down)
//   select     in   1      0 = counting up, 1 = counting down
//   locked     out  1      level; high while FSM in LOCKED
//   err        out  1      one-cycle pulse: mismatch detected while LOCKED
//   wrap       out  1      one-cycle pulse: matching sample was a reload (turn) value
//   expected   out  WIDTH  predicted next value (valid in TRACK/LOCKED)
//   err_count  out  16     saturating count of err pulses since reset
// BEHAVIOUR
//   Reset (rst=1 at edge): state=ACQ, prev=0, match_cnt=0, miss_cnt=0; all outputs 0.
//   Prediction rule (combinational from prev, up, down, select; config sampled every valid cycle):
//     select=0: prev==up or prev==0 -> down, else prev+1
//     select=1: prev==down or prev==0 -> up, else prev-1
//     reload = first branch taken; +1/-1 wrap modulo 2^WIDTH.
//   expected is registered: it equals prediction(prev) with the current config, updated on every
//   prev update.
//   Latency: locked/err/wrap/err_count reflect a sample on the edge after valid is seen (1 cycle).
//   err and wrap are high for exactly one cycle per qualifying sample; they are low when valid=0.
//   FSM (state advances only when valid=1; valid=0 holds all state, outputs except pulses hold):
//     ACQ:    prev<=count_in; match_cnt<=0; -> TRACK.
//     TRACK:  match: prev<=count_in; match_cnt++; if match_cnt+1==LOCK_N -> LOCKED.
//             mismatch: prev<=count_in; match_cnt<=0; stay TRACK; no err pulse.
//     LOCKED: match: prev<=count_in; miss_cnt<=0; wrap pulses if reload.
//             mismatch: err pulse; err_count++ (saturates at 16'hFFFF); prev<=count_in;
//             miss_cnt++; if miss_cnt+1==UNLOCK_N -> ACQ, miss_cnt<=0, locked<=0.
//   wrap fires only on matching samples in TRACK or LOCKED.
//   Config change (up/down/select) mid-stream: no special handling; a resulting mismatch is
//   treated like any other.
//   Mid-operation reset: rst has priority over valid on the same edge; err_count clears.
//   The degenerate sample 0 always predicts a reload (mirrors the counter's zero escape).
// TESTING
//   1. rst, then up=10, down=3, select=0, valid every cycle, stream 3,4,...,10,3 ->
//      locked rises on the edge after the 5th sample (LOCK_N=4); wrap pulses on sample 3 after 10;
//      err never fires.
//   2. Locked as in 1, inject 9 where 7 expected -> err pulse 1 cycle, err_count=1, locked stays;
//      next sample 10 matches from 9 -> miss_cnt clears.
//   3. Locked, 3 consecutive bad samples (each off by +2) -> 3 err pulses, err_count=3,
//      locked drops on the edge after the 3rd, FSM re-acquires from the next sample.
//   4. select=1, up=20, down=5, stream 20,19,...,5,20 with valid toggling 1,0 -> locks after
//      4 matches; valid=0 cycles change nothing; wrap on 20 after 5.
//   5. Sample 0 with select=0, down=3 -> expected=3; sample 127 with up=0 (0 never reached) ->
//      expected=0 (modulo wrap), accepted as a match.
//   6. Force err_count to 16'hFFFE via 2 extra errors -> saturates at 16'hFFFF.
//      Assert rst with valid=1 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/count_sequence_checker.sv
// rtl/count_sequence_checker.sv - run-time integrity monitor for a bounded up/down count stream
// Predicts each sample from the previous one, locks after LOCK_N matches, flags deviations while locked.
module count_sequence_checker #(
    parameter int WIDTH    = 7,
    parameter int LOCK_N   = 4,
    parameter int UNLOCK_N = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_count_in,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_up,
    input  logic [WIDTH-1:0] i_down,
    input  logic             i_select,
    output logic             o_locked,
    output logic             o_err,
    output logic             o_wrap,
    output logic [WIDTH-1:0] o_expected,
    output logic [15:0]      o_err_count
);

    localparam logic [1:0] S_ACQ    = 2'd0;
    localparam logic [1:0] S_TRACK  = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    localparam int MW = $clog2(LOCK_N + 1);
    localparam int UW = $clog2(UNLOCK_N + 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_expected;
    logic [MW-1:0]    r_match_cnt;
    logic [UW-1:0]    r_miss_cnt;
    logic             r_err;
    logic             r_wrap;
    logic [15:0]      r_err_count;

    logic             w_reload;
    logic             w_match;
    logic [MW-1:0]    w_match_next;
    logic [UW-1:0]    w_miss_next;
    logic [WIDTH-1:0] w_pred_prev;
    logic [WIDTH-1:0] w_pred_in;

    // A zero value always takes the reload branch, mirroring the counter's escape from 0.
    function automatic logic f_reload(input logic [WIDTH-1:0] v, input logic [WIDTH-1:0] up,
                                      input logic [WIDTH-1:0] down, input logic sel);
        return sel ? (v == down || v == '0) : (v == up || v == '0);
    endfunction

    function automatic logic [WIDTH-1:0] f_next(input logic [WIDTH-1:0] v, input logic [WIDTH-1:0] up,
                                                input logic [WIDTH-1:0] down, input logic sel);
        if (f_reload(v, up, down, sel))
            return sel ? up : down;
        return sel ? v - WIDTH'(1) : v + WIDTH'(1);
    endfunction

    always_comb begin
        w_reload     = f_reload(r_prev, i_up, i_down, i_select);
        w_pred_prev  = f_next(r_prev, i_up, i_down, i_select);
        w_pred_in    = f_next(i_count_in, i_up, i_down, i_select);
        w_match      = (i_count_in == w_pred_prev);
        w_match_next = r_match_cnt + MW'(1);
        w_miss_next  = r_miss_cnt + UW'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_ACQ;
            r_prev      <= '0;
            r_expected  <= '0;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
            r_err       <= 1'b0;
            r_wrap      <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_err  <= 1'b0;
            r_wrap <= 1'b0;
            if (i_valid) begin
                r_prev     <= i_count_in;
                r_expected <= w_pred_in;
                case (r_state)
                    S_ACQ: begin
                        r_match_cnt <= '0;
                        r_state     <= S_TRACK;
                    end
                    S_TRACK: begin
                        if (w_match) begin
                            r_wrap <= w_reload;
                            if (w_match_next == MW'(LOCK_N)) begin
                                r_match_cnt <= '0;
                                r_state     <= S_LOCKED;
                            end else begin
                                r_match_cnt <= w_match_next;
                            end
                        end else begin
                            r_match_cnt <= '0;
                        end
                    end
                    S_LOCKED: begin
                        if (w_match) begin
                            r_miss_cnt <= '0;
                            r_wrap     <= w_reload;
                        end else begin
                            r_err <= 1'b1;
                            if (r_err_count != 16'hFFFF)
                                r_err_count <= r_err_count + 16'd1;
                            if (w_miss_next == UW'(UNLOCK_N)) begin
                                r_miss_cnt <= '0;
                                r_state    <= S_ACQ;
                            end else begin
                                r_miss_cnt <= w_miss_next;
                            end
                        end
                    end
                    default: r_state <= S_ACQ;
                endcase
            end
        end
    end

    assign o_locked    = (r_state == S_LOCKED);
    assign o_err       = r_err;
    assign o_wrap      = r_wrap;
    assign o_expected  = r_expected;
    assign o_err_count = r_err_count;

endmodule

// File: tb/tb_count_sequence_checker.sv
// tb/tb_count_sequence_checker.sv - directed vector bench for count_sequence_checker
module tb_count_sequence_checker;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [6:0] i_count_in;
    logic       i_valid;
    logic [6:0] i_up;
    logic [6:0] i_down;
    logic       i_select;
    logic       o_locked;
    logic       o_err;
    logic       o_wrap;
    logic [6:0] o_expected;
    logic [15:0] o_err_count;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        rst;
        logic        valid;
        logic [6:0]  cnt;
        logic [6:0]  up;
        logic [6:0]  down;
        logic        sel;
        logic        e_locked;
        logic        e_err;
        logic        e_wrap;
        logic [6:0]  e_exp;
        logic [15:0] e_ec;
    } vec_t;

    vec_t vecs[$];

    count_sequence_checker #(.WIDTH(7), .LOCK_N(4), .UNLOCK_N(3)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_count_in(i_count_in), .i_valid(i_valid),
        .i_up(i_up), .i_down(i_down), .i_select(i_select),
        .o_locked(o_locked), .o_err(o_err), .o_wrap(o_wrap),
        .o_expected(o_expected), .o_err_count(o_err_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic add(input logic r, input logic v, input logic [6:0] c, input logic [6:0] u,
                       input logic [6:0] d, input logic s, input logic l, input logic e,
                       input logic w, input logic [6:0] x, input logic [15:0] ec);
        vec_t t;
        t = '{rst: r, valid: v, cnt: c, up: u, down: d, sel: s,
              e_locked: l, e_err: e, e_wrap: w, e_exp: x, e_ec: ec};
        vecs.push_back(t);
    endtask

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic l, input logic e, input logic w,
                           input logic [6:0] x, input logic [15:0] ec);
        chk({tag, " locked"}, 16'(o_locked), 16'(l));
        chk({tag, " err"}, 16'(o_err), 16'(e));
        chk({tag, " wrap"}, 16'(o_wrap), 16'(w));
        chk({tag, " expected"}, 16'(o_expected), 16'(x));
        chk({tag, " err_count"}, o_err_count, ec);
    endtask

    // Drive at a falling edge, let the rising edge capture, return at the next falling edge.
    task automatic step(input logic r, input logic v, input logic [6:0] c, input logic [6:0] u,
                        input logic [6:0] d, input logic s);
        i_rst = r; i_valid = v; i_count_in = c; i_up = u; i_down = d; i_select = s;
        @(negedge i_clk);
    endtask

    initial begin
        logic       m_locked;
        logic [6:0] m_exp;
        int         m_n;

        // reset, with valid high to show rst wins
        add(1, 1,   5, 10, 3, 0,  0, 0, 0,  0, 0);
        // up-count 3..10 then turn to 3; lock after the 5th sample
        add(0, 1,   3, 10, 3, 0,  0, 0, 0,  4, 0);
        add(0, 1,   4, 10, 3, 0,  0, 0, 0,  5, 0);
        add(0, 1,   5, 10, 3, 0,  0, 0, 0,  6, 0);
        add(0, 1,   6, 10, 3, 0,  0, 0, 0,  7, 0);
        add(0, 1,   7, 10, 3, 0,  1, 0, 0,  8, 0);
        add(0, 1,   8, 10, 3, 0,  1, 0, 0,  9, 0);
        add(0, 1,   9, 10, 3, 0,  1, 0, 0, 10, 0);
        add(0, 1,  10, 10, 3, 0,  1, 0, 0,  3, 0);
        add(0, 1,   3, 10, 3, 0,  1, 0, 1,  4, 0);
        add(0, 1,   4, 10, 3, 0,  1, 0, 0,  5, 0);
        // single bad sample while locked, then recovery from the bad value
        add(0, 1,   5, 10, 3, 0,  1, 0, 0,  6, 0);
        add(0, 1,   6, 10, 3, 0,  1, 0, 0,  7, 0);
        add(0, 1,   9, 10, 3, 0,  1, 1, 0, 10, 1);
        add(0, 1,  10, 10, 3, 0,  1, 0, 0,  3, 1);
        add(0, 1,   3, 10, 3, 0,  1, 0, 1,  4, 1);
        add(0, 1,   4, 10, 3, 0,  1, 0, 0,  5, 1);
        add(0, 1,   5, 10, 3, 0,  1, 0, 0,  6, 1);
        // three consecutive +2 deviations drop lock
        add(0, 1,   8, 10, 3, 0,  1, 1, 0,  9, 2);
        add(0, 1,  11, 10, 3, 0,  1, 1, 0, 12, 3);
        add(0, 1,  14, 10, 3, 0,  0, 1, 0, 15, 4);
        // re-acquire, with a mismatch in TRACK (no err) and a wrap in TRACK
        add(0, 1,   3, 10, 3, 0,  0, 0, 0,  4, 4);
        add(0, 1,   4, 10, 3, 0,  0, 0, 0,  5, 4);
        add(0, 1,   9, 10, 3, 0,  0, 0, 0, 10, 4);
        add(0, 1,  10, 10, 3, 0,  0, 0, 0,  3, 4);
        add(0, 1,   3, 10, 3, 0,  0, 0, 1,  4, 4);
        add(0, 1,   4, 10, 3, 0,  0, 0, 0,  5, 4);
        add(0, 1,   5, 10, 3, 0,  1, 0, 0,  6, 4);
        add(0, 0,  99, 10, 3, 0,  1, 0, 0,  6, 4);
        add(0, 1,   9, 10, 3, 0,  1, 1, 0, 10, 5);
        add(0, 0,  99, 10, 3, 0,  1, 0, 0, 10, 5);
        // zero sample predicts a reload; 127 wraps to 0 when up=0
        add(1, 0,   0, 10, 3, 0,  0, 0, 0,  0, 0);
        add(0, 1,   0, 10, 3, 0,  0, 0, 0,  3, 0);
        add(0, 1,   3, 10, 3, 0,  0, 0, 1,  4, 0);
        add(1, 0,   0,  0, 3, 0,  0, 0, 0,  0, 0);
        add(0, 1, 127,  0, 3, 0,  0, 0, 0,  0, 0);
        add(0, 1,   0,  0, 3, 0,  0, 0, 0,  3, 0);

        for (int k = 0; k < vecs.size(); k++) begin
            step(vecs[k].rst, vecs[k].valid, vecs[k].cnt, vecs[k].up, vecs[k].down, vecs[k].sel);
            chk_all($sformatf("vec%0d", k), vecs[k].e_locked, vecs[k].e_err, vecs[k].e_wrap,
                    vecs[k].e_exp, vecs[k].e_ec);
        end

        // down-count 20..5 then turn to 20, valid toggling 1,0
        step(1, 0, 0, 20, 5, 1);
        chk_all("dn rst", 0, 0, 0, 0, 0);
        step(0, 1, 20, 20, 5, 1);
        chk_all("dn 20", 0, 0, 0, 19, 0);
        m_locked = 1'b0;
        m_exp    = 7'd19;
        m_n      = 0;
        for (int v = 19; v >= 5; v--) begin
            step(0, 0, 7'(v + 40), 20, 5, 1);
            chk_all($sformatf("dn idle%0d", v), m_locked, 0, 0, m_exp, 0);
            m_n++;
            if (m_n == 4) m_locked = 1'b1;
            m_exp = (v == 5) ? 7'd20 : 7'(v - 1);
            step(0, 1, 7'(v), 20, 5, 1);
            chk_all($sformatf("dn %0d", v), m_locked, 0, 0, m_exp, 0);
        end
        step(0, 1, 20, 20, 5, 1);
        chk_all("dn turn", 1, 0, 1, 19, 0);

        // saturation of err_count, then reset with valid high
        step(1, 0, 0, 10, 3, 0);
        for (int v = 3; v <= 7; v++) step(0, 1, 7'(v), 10, 3, 0);
        chk_all("sat lock", 1, 0, 0, 8, 0);
        force dut.r_err_count = 16'hFFFE;
        step(0, 0, 0, 10, 3, 0);
        release dut.r_err_count;
        step(0, 1, 10, 10, 3, 0);
        chk_all("sat 1", 1, 1, 0, 3, 16'hFFFF);
        step(0, 1, 5, 10, 3, 0);
        chk_all("sat 2", 1, 1, 0, 6, 16'hFFFF);
        step(1, 1, 6, 10, 3, 0);
        chk_all("rst mid", 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
